// File: rtl/pixel_proc_pkg.sv
// Shared definitions for the streaming pixel processor.
//   mode_e  : point-operation encodings (values 5..7 behave as bypass)
//   state_e : frame-control FSM states
//   mark_t  : line/frame markers that travel alongside each beat
//   pix_off : bit offset of pixel p inside a packed beat
package pixel_proc_pkg;

    typedef enum logic [2:0] {
        MODE_BYPASS = 3'd0,
        MODE_ADD    = 3'd1,
        MODE_SUB    = 3'd2,
        MODE_INV    = 3'd3,
        MODE_THRESH = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic sof;
        logic eof;
        logic sol;
        logic eol;
    } mark_t;

    localparam int unsigned PIX_CH = 3;

    // Pixel p occupies [pix_off(p,dw) +: 3*dw], packed {R,G,B}.
    function automatic int unsigned pix_off(input int unsigned p, input int unsigned dw);
        return p * PIX_CH * dw;
    endfunction

endpackage

// File: rtl/pixel_op_lane.sv
// One pixel's two-stage point-operation datapath.
//   clk, rst_n : clock, async active-low reset
//   ld1        : load stage 1 from pix_in (input beat accepted)
//   ld2        : load stage 2 / pix_out from stage 1
//   mode, value, threshold : frame-latched operation controls
//   pix_in     : {R,G,B} input pixel
//   pix_out    : {R,G,B} processed pixel (registered)
module pixel_op_lane
    import pixel_proc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld1,
    input  logic            ld2,
    input  logic [2:0]      mode,
    input  logic [DW-1:0]   value,
    input  logic [DW-1:0]   threshold,
    input  logic [3*DW-1:0] pix_in,
    output logic [3*DW-1:0] pix_out
);

    localparam logic [DW-1:0] MAX = '1;

    // Channel index 0 = B, 1 = G, 2 = R (R sits in the MSBs).
    logic [2:0][DW-1:0] ch_in;
    logic [2:0][DW-1:0] ch_s1;
    logic [2:0][DW:0]   add_s1;
    logic [2:0][DW:0]   sub_s1;   // MSB set means the difference went negative
    logic [DW+1:0]      sum_s1;
    logic [DW-1:0]      grey;
    logic [2:0][DW-1:0] res;

    assign ch_in = pix_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_s1  <= '0;
            add_s1 <= '0;
            sub_s1 <= '0;
            sum_s1 <= '0;
        end else if (ld1) begin
            for (int c = 0; c < 3; c++) begin
                ch_s1[c]  <= ch_in[c];
                add_s1[c] <= {1'b0, ch_in[c]} + {1'b0, value};
                sub_s1[c] <= {1'b0, ch_in[c]} - {1'b0, value};
            end
            sum_s1 <= (DW+2)'(ch_in[0]) + (DW+2)'(ch_in[1]) + (DW+2)'(ch_in[2]);
        end
    end

    // floor(sum/3) always fits DW bits since sum <= 3*MAX.
    always_comb begin
        grey = DW'(sum_s1 / (DW+2)'(3));
        res  = ch_s1;
        case (mode)
            MODE_ADD:
                for (int c = 0; c < 3; c++)
                    res[c] = add_s1[c][DW] ? MAX : add_s1[c][DW-1:0];
            MODE_SUB:
                for (int c = 0; c < 3; c++)
                    res[c] = sub_s1[c][DW] ? '0 : sub_s1[c][DW-1:0];
            MODE_INV:
                for (int c = 0; c < 3; c++)
                    res[c] = MAX - grey;
            MODE_THRESH:
                for (int c = 0; c < 3; c++)
                    res[c] = (grey > threshold) ? MAX : '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pix_out <= '0;
        else if (ld2)
            pix_out <= res;
    end

endmodule

// File: rtl/pixel_stream_proc.sv
// Streaming RGB point-operation processor, PIX_PER_CLK pixels per beat.
//   HCLK, HRESETn        : clock, async active-low reset
//   start                : frame start request (sampled in ST_IDLE)
//   mode/value/threshold : operation controls, latched at frame start
//   in_valid/in_ready/in_data     : input beat handshake
//   out_valid/out_ready/out_data  : output beat handshake
//   out_sol/eol/sof/eof  : line/frame markers of the current output beat
//   busy                 : frame in progress (ST_RUN, ST_DRAIN)
//   ctrl_done            : one-cycle pulse after the eof beat leaves
module pixel_stream_proc
    import pixel_proc_pkg::*;
#(
    parameter int WIDTH       = 512,
    parameter int HEIGHT      = 512,
    parameter int DW          = 8,
    parameter int PIX_PER_CLK = 2
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        start,
    input  logic [2:0]                  mode,
    input  logic [DW-1:0]               value,
    input  logic [DW-1:0]               threshold,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PIX_PER_CLK*3*DW-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PIX_PER_CLK*3*DW-1:0] out_data,
    output logic                        out_sol,
    output logic                        out_eol,
    output logic                        out_sof,
    output logic                        out_eof,
    output logic                        busy,
    output logic                        ctrl_done
);

    localparam int BEATS  = WIDTH / PIX_PER_CLK;
    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int STAGES = 2;

    state_e              state, state_nx;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [2:0]          mode_q;
    logic [DW-1:0]       value_q, thresh_q;
    logic [STAGES:1]     vld_pipe;
    mark_t               mk_in, mk_s1, mk_s2;
    logic                en, accept, ld2, last_col, last_row, eof_fire;

    // Whole pipeline advances together; stage 2 only blocks when it holds
    // a beat the sink has not taken.
    assign en       = !vld_pipe[STAGES] || out_ready;
    assign in_ready = en && (state == ST_RUN);
    assign accept   = in_valid && in_ready;
    assign ld2      = en && vld_pipe[1];

    assign last_col = (col == CW'(BEATS - 1));
    assign last_row = (row == RW'(HEIGHT - 1));

    always_comb begin
        mk_in     = '0;
        mk_in.sol = (col == '0);
        mk_in.eol = last_col;
        mk_in.sof = (col == '0) && (row == '0);
        mk_in.eof = last_col && last_row;
    end

    // Markers are gated so they never show without a valid beat.
    assign out_valid = vld_pipe[STAGES];
    assign out_sol   = out_valid && mk_s2.sol;
    assign out_eol   = out_valid && mk_s2.eol;
    assign out_sof   = out_valid && mk_s2.sof;
    assign out_eof   = out_valid && mk_s2.eof;
    assign eof_fire  = out_eof && out_ready;

    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign ctrl_done = (state == ST_DONE);

    // ---------------- frame control FSM ----------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start)                        state_nx = ST_RUN;
            ST_RUN:   if (accept && last_col && last_row) state_nx = ST_DRAIN;
            ST_DRAIN: if (eof_fire)                     state_nx = ST_DONE;
            ST_DONE:                                    state_nx = ST_IDLE;
            default:                                    state_nx = ST_IDLE;
        endcase
    end

    // ---------------- counters and frame configuration ----------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col      <= '0;
            row      <= '0;
            mode_q   <= '0;
            value_q  <= '0;
            thresh_q <= '0;
        end else if (state == ST_IDLE && start) begin
            col      <= '0;
            row      <= '0;
            mode_q   <= mode;
            value_q  <= value;
            thresh_q <= threshold;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // ---------------- valid / marker pipeline ----------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vld_pipe <= '0;
            mk_s1    <= '0;
            mk_s2    <= '0;
        end else if (en) begin
            vld_pipe[1] <= accept;
            vld_pipe[2] <= vld_pipe[1];
            if (accept)      mk_s1 <= mk_in;
            if (vld_pipe[1]) mk_s2 <= mk_s1;
        end
    end

    // ---------------- per-pixel datapath ----------------
    for (genvar p = 0; p < PIX_PER_CLK; p++) begin : g_lane
        pixel_op_lane #(.DW(DW)) u_lane (
            .clk       (HCLK),
            .rst_n     (HRESETn),
            .ld1       (accept),
            .ld2       (ld2),
            .mode      (mode_q),
            .value     (value_q),
            .threshold (thresh_q),
            .pix_in    (in_data[pix_off(p, DW) +: 3*DW]),
            .pix_out   (out_data[pix_off(p, DW) +: 3*DW])
        );
    end

endmodule

// File: tb/tb_pixel_stream_proc.sv
module tb_pixel_stream_proc;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 4;
    localparam int DW     = 8;
    localparam int PPC    = 2;
    localparam int BEATS  = WIDTH / PPC;
    localparam int NB     = BEATS * HEIGHT;
    localparam int DATA_W = PPC * 3 * DW;

    typedef logic [DATA_W+3:0] obs_t;   // {sof,eof,sol,eol,data}

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        mode = '0;
    logic [DW-1:0]     value = '0;
    logic [DW-1:0]     threshold = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_sol, out_eol, out_sof, out_eof, busy, ctrl_done;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ready_pct = 100;
    obs_t out_q[$];
    int   out_cyc[$];
    int   acc_q[$];
    int   done_q[$];
    bit   stall_prev = 1'b0;
    obs_t stall_val = '0;
    logic [DATA_W-1:0] in_beats [NB];
    obs_t              exp_beats [NB];

    pixel_stream_proc #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DW(DW), .PIX_PER_CLK(PPC)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode), .value(value),
        .threshold(threshold), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof), .out_eof(out_eof),
        .busy(busy), .ctrl_done(ctrl_done)
    );

    always #5 HCLK = ~HCLK;

    function automatic obs_t cur_obs();
        return {out_sof, out_eof, out_sol, out_eol, out_data};
    endfunction

    // Reference point operation on one {R,G,B} pixel, plain integer arithmetic.
    function automatic logic [3*DW-1:0] ref_px(input int m, input int v, input int t,
                                               input logic [3*DW-1:0] px);
        int c [3];
        int g;
        int mx;
        mx = (1 << DW) - 1;
        for (int i = 0; i < 3; i++) c[i] = int'(px[i*DW +: DW]);
        g = (c[0] + c[1] + c[2]) / 3;
        for (int i = 0; i < 3; i++) begin
            case (m)
                1: c[i] = (c[i] + v > mx) ? mx : c[i] + v;
                2: c[i] = (c[i] - v < 0) ? 0 : c[i] - v;
                3: c[i] = mx - g;
                4: c[i] = (g > t) ? mx : 0;
                default: ;
            endcase
        end
        return {DW'(c[2]), DW'(c[1]), DW'(c[0])};
    endfunction

    function automatic void gen_frame();
        for (int k = 0; k < NB; k++) in_beats[k] = DATA_W'({$urandom(), $urandom()});
    endfunction

    // Expected output stream: per-pixel op plus markers from beat position.
    function automatic void calc_exp(input int m, input int v, input int t);
        logic [DATA_W-1:0] d;
        int col, row;
        bit sol, eol;
        for (int k = 0; k < NB; k++) begin
            for (int p = 0; p < PPC; p++)
                d[p*3*DW +: 3*DW] = ref_px(m, v, t, in_beats[k][p*3*DW +: 3*DW]);
            col = k % BEATS;
            row = k / BEATS;
            sol = (col == 0);
            eol = (col == BEATS - 1);
            exp_beats[k] = {sol && row == 0, eol && row == HEIGHT - 1, sol, eol, d};
        end
    endfunction

    // One clock: sample at negedge (capture, stall hold, done), drive after posedge.
    task automatic tick(output bit acc);
        @(negedge HCLK);
        acc = in_valid && in_ready;
        if (!HRESETn) stall_prev = 1'b0;
        if (stall_prev) begin
            n_cmp++;
            if (!out_valid || cur_obs() !== stall_val) begin
                n_bad++;
                $display("FAIL stall_hold cyc=%0d got valid=%0b obs=%h want valid=1 obs=%h",
                         cyc, out_valid, cur_obs(), stall_val);
            end
        end
        stall_prev = out_valid && !out_ready;
        stall_val  = cur_obs();
        if (out_valid && out_ready) begin
            out_q.push_back(cur_obs());
            out_cyc.push_back(cyc);
        end
        if (ctrl_done) done_q.push_back(cyc);
        if (acc) acc_q.push_back(cyc);
        @(posedge HCLK);
        cyc++;
        #1;
        out_ready = (int'($urandom_range(99)) < ready_pct);
    endtask

    task automatic ticks(input int n);
        bit a;
        repeat (n) tick(a);
    endtask

    task automatic start_frame(input int m, input int v, input int t);
        bit a;
        mode = 3'(m); value = DW'(v); threshold = DW'(t);
        start = 1'b1;
        tick(a);
        start = 1'b0;
        // scramble controls: the frame must keep using the latched copy
        mode = 3'($urandom()); value = DW'($urandom()); threshold = DW'($urandom());
    endtask

    task automatic send_beats(input int n, input int gap_pct, input int perturb_at);
        bit a;
        int guard;
        for (int k = 0; k < n; k++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                tick(a);
            end
            in_valid = 1'b1;
            in_data  = in_beats[k];
            if (k == perturb_at) begin
                mode = 3'd3; value = DW'(77); threshold = DW'(1); start = 1'b1;
            end
            a = 1'b0;
            guard = 0;
            while (!a && guard < 2000) begin
                tick(a);
                start = 1'b0;
                guard++;
            end
            if (!a) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout beat=%0d got no acceptance want acceptance", k);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int dbase, input int budget);
        int g = 0;
        bit a;
        while (done_q.size() == dbase && g < budget) begin
            tick(a);
            g++;
        end
        if (done_q.size() == dbase) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout got no ctrl_done want ctrl_done within %0d cycles", budget);
        end
        ticks(3);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        HRESETn = 1'b0;
        ticks(2);
        n_cmp++;
        if ({in_ready, out_valid, out_sol, out_eol, out_sof, out_eof, busy, ctrl_done} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b want 00000000",
                     {in_ready, out_valid, out_sol, out_eol, out_sof, out_eof, busy, ctrl_done});
        end
        n_cmp++;
        if (out_data !== '0) begin
            n_bad++; $display("FAIL reset_data got %h want 0", out_data);
        end
        HRESETn = 1'b1;
        ticks(2);
        n_cmp++;
        if ({in_ready, busy, out_valid} !== 3'b000) begin
            n_bad++; $display("FAIL idle_after_reset got %b want 000", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_bypass_framing();
        int base, abase, dbase;
        ready_pct = 100;
        gen_frame();
        calc_exp(0, 0, 0);
        base = out_q.size(); abase = acc_q.size(); dbase = done_q.size();
        start_frame(0, 0, 0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_run got %b want 1", busy);
        end
        send_beats(NB, 0, -1);
        wait_done(dbase, 500);
        n_cmp++;
        if (out_q.size() - base != NB) begin
            n_bad++; $display("FAIL bypass_count got %0d want %0d", out_q.size() - base, NB);
        end
        for (int k = 0; k < NB && base + k < out_q.size(); k++) begin
            n_cmp++;
            if (out_q[base+k] !== exp_beats[k]) begin
                n_bad++; $display("FAIL bypass_beat%0d got %h want %h", k, out_q[base+k], exp_beats[k]);
            end
        end
        if (out_q.size() > base && acc_q.size() > abase) begin
            n_cmp++;
            if (out_cyc[base] - acc_q[abase] != 2) begin
                n_bad++; $display("FAIL latency got %0d want 2", out_cyc[base] - acc_q[abase]);
            end
        end
        n_cmp++;
        if (done_q.size() - dbase != 1) begin
            n_bad++; $display("FAIL bypass_done_count got %0d want 1", done_q.size() - dbase);
        end else if (out_q.size() - base == NB) begin
            n_cmp++;
            if (done_q[dbase] - out_cyc[base+NB-1] != 1) begin
                n_bad++; $display("FAIL done_timing got %0d want 1", done_q[dbase] - out_cyc[base+NB-1]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL busy_idle got %b want 0", busy);
        end
    endtask

    task automatic test_point_ops();
        int                cm [6] = '{1, 2, 3, 4, 4, 3};
        int                cv [6] = '{100, 100, 0, 0, 0, 0};
        int                ct [6] = '{0, 0, 0, 60, 59, 0};
        logic [3*DW-1:0]   cpx [6] = '{24'hC86400, 24'h3264FF, 24'h1E3C5B,
                                       24'h1E3C5B, 24'h1E3C5B, 24'hFFFFFF};
        logic [3*DW-1:0]   cex [6] = '{24'hFFC864, 24'h00009B, 24'hC3C3C3,
                                       24'h000000, 24'hFFFFFF, 24'h000000};
        int base, dbase;
        ready_pct = 80;
        for (int i = 0; i < 6; i++) begin
            gen_frame();
            in_beats[0][3*DW-1:0] = cpx[i];
            calc_exp(cm[i], cv[i], ct[i]);
            base = out_q.size(); dbase = done_q.size();
            start_frame(cm[i], cv[i], ct[i]);
            send_beats(NB, 20, -1);
            wait_done(dbase, 2000);
            n_cmp++;
            if (out_q.size() - base != NB) begin
                n_bad++; $display("FAIL op%0d_count got %0d want %0d", i, out_q.size() - base, NB);
            end else begin
                n_cmp++;
                if (out_q[base][3*DW-1:0] !== cex[i]) begin
                    n_bad++; $display("FAIL op%0d_directed got %h want %h", i, out_q[base][3*DW-1:0], cex[i]);
                end
            end
            for (int k = 0; k < NB && base + k < out_q.size(); k++) begin
                n_cmp++;
                if (out_q[base+k] !== exp_beats[k]) begin
                    n_bad++; $display("FAIL op%0d_beat%0d got %h want %h", i, k, out_q[base+k], exp_beats[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int base, dbase, m, v, t;
        ready_pct = 30;
        for (int f = 0; f < 3; f++) begin
            m = int'($urandom_range(7)); v = int'($urandom_range(255)); t = int'($urandom_range(255));
            gen_frame();
            calc_exp(m, v, t);
            base = out_q.size(); dbase = done_q.size();
            start_frame(m, v, t);
            send_beats(NB, 30, -1);
            wait_done(dbase, 5000);
            n_cmp++;
            if (out_q.size() - base != NB) begin
                n_bad++; $display("FAIL bp%0d_count got %0d want %0d", f, out_q.size() - base, NB);
            end
            for (int k = 0; k < NB && base + k < out_q.size(); k++) begin
                n_cmp++;
                if (out_q[base+k] !== exp_beats[k]) begin
                    n_bad++; $display("FAIL bp%0d_beat%0d got %h want %h", f, k, out_q[base+k], exp_beats[k]);
                end
            end
            n_cmp++;
            if (done_q.size() - dbase != 1) begin
                n_bad++; $display("FAIL bp%0d_done got %0d want 1", f, done_q.size() - dbase);
            end
        end
        ready_pct = 100;
    endtask

    task automatic test_mode_latch();
        int base, dbase;
        ready_pct = 70;
        gen_frame();
        calc_exp(1, 40, 0);
        base = out_q.size(); dbase = done_q.size();
        start_frame(1, 40, 0);
        send_beats(NB, 10, 5);   // mode/value change plus start pulse at beat 5
        wait_done(dbase, 2000);
        n_cmp++;
        if (out_q.size() - base != NB) begin
            n_bad++; $display("FAIL latch_count got %0d want %0d", out_q.size() - base, NB);
        end
        for (int k = 0; k < NB && base + k < out_q.size(); k++) begin
            n_cmp++;
            if (out_q[base+k] !== exp_beats[k]) begin
                n_bad++; $display("FAIL latch_beat%0d got %h want %h", k, out_q[base+k], exp_beats[k]);
            end
        end
        n_cmp++;
        if (done_q.size() - dbase != 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL latch_restart got done=%0d busy=%b want done=1 busy=0",
                              done_q.size() - dbase, busy);
        end
        ready_pct = 100;
    endtask

    task automatic test_reset_midframe();
        int base, dbase;
        ready_pct = 100;
        gen_frame();
        dbase = done_q.size();
        start_frame(2, 20, 0);
        send_beats(10, 0, -1);
        #2 HRESETn = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_sol, out_eol, out_sof, out_eof, busy, ctrl_done} !== 8'h00
            || out_data !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs got ctrl=%b data=%h want ctrl=00000000 data=0",
                     {in_ready, out_valid, out_sol, out_eol, out_sof, out_eof, busy, ctrl_done}, out_data);
        end
        ticks(3);
        HRESETn = 1'b1;
        ticks(4);
        n_cmp++;
        if (done_q.size() != dbase) begin
            n_bad++; $display("FAIL midreset_done got %0d want 0", done_q.size() - dbase);
        end
        gen_frame();
        calc_exp(4, 0, 128);
        base = out_q.size(); dbase = done_q.size();
        start_frame(4, 0, 128);
        send_beats(NB, 0, -1);
        wait_done(dbase, 500);
        n_cmp++;
        if (out_q.size() - base != NB) begin
            n_bad++; $display("FAIL restart_count got %0d want %0d", out_q.size() - base, NB);
        end else begin
            n_cmp++;
            if (out_q[base][DATA_W+3] !== 1'b1) begin
                n_bad++; $display("FAIL restart_sof got %b want 1", out_q[base][DATA_W+3]);
            end
        end
        for (int k = 0; k < NB && base + k < out_q.size(); k++) begin
            n_cmp++;
            if (out_q[base+k] !== exp_beats[k]) begin
                n_bad++; $display("FAIL restart_beat%0d got %h want %h", k, out_q[base+k], exp_beats[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass_framing();
        test_point_ops();
        test_backpressure();
        test_mode_latch();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
